// File: rtl/draw_buttons.sv
// Overlays the PLAY, MULTI and MENU button boxes on the background pixel stream.
// Also latches mouse hover once per frame and emits one-cycle click pulses.
module draw_buttons #(
  parameter int PLAY_X       = 432,
  parameter int PLAY_Y       = 400,
  parameter int MULTI_X      = 432,
  parameter int MULTI_Y      = 540,
  parameter int MENU_X       = 432,
  parameter int MENU_Y       = 520,
  parameter int BOX_W        = 128,
  parameter int BOX_H        = 80,
  parameter int BORDER       = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        display_buttons_m_and_s,
  input  logic        display_menu_button,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mouse_left,
  output logic [11:0] hcount_out,
  output logic [11:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        play_click,
  output logic        multi_click,
  output logic        menu_click
);

  localparam logic [11:0] PX = 12'(PLAY_X);
  localparam logic [11:0] PY = 12'(PLAY_Y);
  localparam logic [11:0] SX = 12'(MULTI_X);
  localparam logic [11:0] SY = 12'(MULTI_Y);
  localparam logic [11:0] MX = 12'(MENU_X);
  localparam logic [11:0] MY = 12'(MENU_Y);
  localparam logic [11:0] W  = 12'(BOX_W);
  localparam logic [11:0] H  = 12'(BOX_H);
  localparam logic [11:0] B  = 12'(BORDER);
  localparam int          CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] LAST_FRAME = CW'(BLINK_FRAMES - 1);

  function automatic logic in_box(input logic [11:0] x, input logic [11:0] y,
                                  input logic [11:0] bx, input logic [11:0] by);
    return (x >= bx) && (x < bx + W) && (y >= by) && (y < by + H);
  endfunction

  function automatic logic in_border(input logic [11:0] x, input logic [11:0] y,
                                     input logic [11:0] bx, input logic [11:0] by);
    return in_box(x, y, bx, by) &&
           ((x < bx + B) || (x >= bx + W - B) || (y < by + B) || (y >= by + H - B));
  endfunction

  logic        vis_ms;
  logic        vsync_d;
  logic        mouse_left_d;
  logic        vsync_rise;
  logic        press;
  logic        hit_play;
  logic        hit_multi;
  logic        hit_menu;
  logic        border_hit;
  logic        hover_play;
  logic        hover_multi;
  logic        hover_menu;
  logic [CW-1:0] frame_cnt;
  logic        blink_phase;

  logic [11:0] hcount_s1;
  logic [11:0] vcount_s1;
  logic        hsync_s1;
  logic        vsync_s1;
  logic        hblnk_s1;
  logic        vblnk_s1;
  logic [11:0] rgb_s1;
  logic        border_s1;
  logic        fill_play_s1;
  logic        fill_multi_s1;
  logic        fill_menu_s1;
  logic [11:0] rgb_next;

  // MENU takes precedence, so PLAY/MULTI are hidden whenever it is shown.
  assign vis_ms     = display_buttons_m_and_s && !display_menu_button;
  assign vsync_rise = vsync_in && !vsync_d;
  assign press      = mouse_left && !mouse_left_d;
  assign hit_play   = vis_ms && in_box(xpos, ypos, PX, PY);
  assign hit_multi  = vis_ms && in_box(xpos, ypos, SX, SY) && !hit_play;
  assign hit_menu   = display_menu_button && in_box(xpos, ypos, MX, MY);
  assign border_hit = (vis_ms && (in_border(hcount_in, vcount_in, PX, PY) ||
                                  in_border(hcount_in, vcount_in, SX, SY))) ||
                      (display_menu_button && in_border(hcount_in, vcount_in, MX, MY));

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_s1     <= '0;
      vcount_s1     <= '0;
      hsync_s1      <= 1'b0;
      vsync_s1      <= 1'b0;
      hblnk_s1      <= 1'b0;
      vblnk_s1      <= 1'b0;
      rgb_s1        <= '0;
      border_s1     <= 1'b0;
      fill_play_s1  <= 1'b0;
      fill_multi_s1 <= 1'b0;
      fill_menu_s1  <= 1'b0;
    end else begin
      hcount_s1     <= hcount_in;
      vcount_s1     <= vcount_in;
      hsync_s1      <= hsync_in;
      vsync_s1      <= vsync_in;
      hblnk_s1      <= hblnk_in;
      vblnk_s1      <= vblnk_in;
      rgb_s1        <= rgb_in;
      border_s1     <= border_hit;
      fill_play_s1  <= vis_ms && in_box(hcount_in, vcount_in, PX, PY);
      fill_multi_s1 <= vis_ms && in_box(hcount_in, vcount_in, SX, SY);
      fill_menu_s1  <= display_menu_button && in_box(hcount_in, vcount_in, MX, MY);
    end
  end

  always_comb begin
    rgb_next = rgb_s1;
    if (hblnk_s1 || vblnk_s1)
      rgb_next = 12'h000;
    else if (border_s1)
      rgb_next = 12'hfff;
    else if (fill_play_s1)
      rgb_next = hover_play ? 12'h0f0 : 12'h444;
    else if (fill_multi_s1)
      rgb_next = hover_multi ? 12'h0f0 : 12'h444;
    else if (fill_menu_s1)
      rgb_next = hover_menu ? 12'h0f0 : (blink_phase ? 12'h00f : 12'h444);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_s1;
      vcount_out <= vcount_s1;
      hsync_out  <= hsync_s1;
      vsync_out  <= vsync_s1;
      hblnk_out  <= hblnk_s1;
      vblnk_out  <= vblnk_s1;
      rgb_out    <= rgb_next;
    end
  end

  // Edge registers track their inputs during reset so a level already high at release is not an edge.
  always_ff @(posedge pclk) begin
    vsync_d      <= vsync_in;
    mouse_left_d <= mouse_left;
    if (rst) begin
      hover_play  <= 1'b0;
      hover_multi <= 1'b0;
      hover_menu  <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      play_click  <= 1'b0;
      multi_click <= 1'b0;
      menu_click  <= 1'b0;
    end else begin
      if (vsync_rise) begin
        hover_play  <= in_box(xpos, ypos, PX, PY);
        hover_multi <= in_box(xpos, ypos, SX, SY);
        hover_menu  <= in_box(xpos, ypos, MX, MY);
      end
      if (!display_menu_button) begin
        frame_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (vsync_rise) begin
        if (frame_cnt == LAST_FRAME) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + CW'(1);
        end
      end
      play_click  <= press && hit_play;
      multi_click <= press && hit_multi;
      menu_click  <= press && hit_menu;
    end
  end

endmodule

// File: tb/tb_draw_buttons.sv
// Bench for draw_buttons: directed pixel table, multi-cycle hover/click/blink/reset
// sequences, and a randomized run against a rectangle-arithmetic reference model.
module tb_draw_buttons;

  localparam int BF     = 2;
  localparam int BOX_W  = 128;
  localparam int BOX_H  = 80;
  localparam int BD     = 4;
  localparam int N_RAND = 2500;

  logic        pclk;
  logic        rst;
  logic [11:0] hcount_in, vcount_in, xpos, ypos, rgb_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic        display_buttons_m_and_s, display_menu_button, mouse_left;
  logic [11:0] hcount_out, vcount_out, rgb_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic        play_click, multi_click, menu_click;

  int total = 0;
  int bad   = 0;

  draw_buttons #(.BLINK_FRAMES(BF)) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .display_buttons_m_and_s(display_buttons_m_and_s), .display_menu_button(display_menu_button),
    .xpos(xpos), .ypos(ypos), .mouse_left(mouse_left),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out),
    .play_click(play_click), .multi_click(multi_click), .menu_click(menu_click)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic [11:0] h;
    logic [11:0] v;
    logic        hb;
    logic        dms;
    logic        dmb;
    logic [11:0] rgb;
    logic [11:0] exp;
  } vec_t;

  typedef struct {
    logic [11:0] h;
    logic [11:0] v;
    logic [3:0]  sync;
    logic [11:0] rgb;
  } pix_t;

  // Box origins indexed 0=PLAY, 1=MULTI, 2=MENU.
  int bx[3] = '{432, 432, 432};
  int by[3] = '{400, 540, 520};

  bit m_hov[3];
  int m_frames;
  bit m_vs_prev, m_ml_prev;

  task automatic check_output(input string name, input logic [11:0] actual, input logic [11:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [11:0] h, input logic [11:0] v, input logic hb,
                                input logic dms, input logic dmb, input logic [11:0] rgb);
    hcount_in = h;
    vcount_in = v;
    hblnk_in  = hb;
    display_buttons_m_and_s = dms;
    display_menu_button     = dmb;
    rgb_in    = rgb;
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b1;
    tick(1);
    vsync_in = 1'b0;
    tick(1);
  endtask

  task automatic count_clicks(input int cycles, input int high_cycles,
                              output int np, output int nm, output int nn, output int multi);
    np = 0; nm = 0; nn = 0; multi = 0;
    mouse_left = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      tick(1);
      if (i == high_cycles - 1) mouse_left = 1'b0;
      np += int'(play_click);
      nm += int'(multi_click);
      nn += int'(menu_click);
      if (int'(play_click) + int'(multi_click) + int'(menu_click) > 1) multi++;
    end
  endtask

  function automatic bit m_in_box(int i, int x, int y);
    return x >= bx[i] && x < bx[i] + BOX_W && y >= by[i] && y < by[i] + BOX_H;
  endfunction

  function automatic bit m_border(int i, int x, int y);
    bit inner;
    inner = x >= bx[i] + BD && x < bx[i] + BOX_W - BD && y >= by[i] + BD && y < by[i] + BOX_H - BD;
    return m_in_box(i, x, y) && !inner;
  endfunction

  function automatic bit m_visible(int i, bit dms, bit dmb);
    return (i == 2) ? dmb : (dms && !dmb);
  endfunction

  function automatic logic [11:0] m_colour(int x, int y, bit blank, bit dms, bit dmb,
                                           logic [11:0] bg, bit phase);
    if (blank) return 12'h000;
    for (int i = 0; i < 3; i++)
      if (m_visible(i, dms, dmb) && m_border(i, x, y)) return 12'hfff;
    for (int i = 0; i < 3; i++)
      if (m_visible(i, dms, dmb) && m_in_box(i, x, y))
        return m_hov[i] ? 12'h0f0 : ((i == 2 && phase) ? 12'h00f : 12'h444);
    return bg;
  endfunction

  initial begin
    vec_t        vecs[20];
    logic [11:0] blink_exp[7];
    int          np, nm, nn, multi;
    pix_t        p1, p2, pn;
    logic [2:0]  c1, cn;
    int          pushed;
    bit          vs_rise, press, phase;

    vecs[0]  = '{12'd433, 12'd401, 1'b0, 1'b1, 1'b0, 12'h123, 12'hfff};
    vecs[1]  = '{12'd500, 12'd440, 1'b0, 1'b1, 1'b0, 12'h123, 12'h444};
    vecs[2]  = '{12'd100, 12'd100, 1'b0, 1'b1, 1'b0, 12'habc, 12'habc};
    vecs[3]  = '{12'd500, 12'd440, 1'b1, 1'b1, 1'b0, 12'h123, 12'h000};
    vecs[4]  = '{12'd431, 12'd440, 1'b0, 1'b1, 1'b0, 12'h5a5, 12'h5a5};
    vecs[5]  = '{12'd432, 12'd440, 1'b0, 1'b1, 1'b0, 12'h5a5, 12'hfff};
    vecs[6]  = '{12'd435, 12'd440, 1'b0, 1'b1, 1'b0, 12'h5a5, 12'hfff};
    vecs[7]  = '{12'd436, 12'd440, 1'b0, 1'b1, 1'b0, 12'h5a5, 12'h444};
    vecs[8]  = '{12'd559, 12'd440, 1'b0, 1'b1, 1'b0, 12'h5a5, 12'hfff};
    vecs[9]  = '{12'd560, 12'd440, 1'b0, 1'b1, 1'b0, 12'h5a5, 12'h5a5};
    vecs[10] = '{12'd500, 12'd479, 1'b0, 1'b1, 1'b0, 12'h5a5, 12'hfff};
    vecs[11] = '{12'd500, 12'd480, 1'b0, 1'b1, 1'b0, 12'h5a5, 12'h5a5};
    vecs[12] = '{12'd500, 12'd440, 1'b0, 1'b0, 1'b0, 12'h5a5, 12'h5a5};
    vecs[13] = '{12'd500, 12'd440, 1'b0, 1'b1, 1'b1, 12'h5a5, 12'h5a5};
    vecs[14] = '{12'd480, 12'd560, 1'b0, 1'b0, 1'b1, 12'h5a5, 12'h444};
    vecs[15] = '{12'd480, 12'd580, 1'b0, 1'b1, 1'b0, 12'h5a5, 12'h444};
    vecs[16] = '{12'd480, 12'd536, 1'b0, 1'b1, 1'b0, 12'h5a5, 12'h5a5};
    vecs[17] = '{12'd480, 12'd536, 1'b0, 1'b1, 1'b1, 12'h5a5, 12'h444};
    vecs[18] = '{12'd480, 12'd521, 1'b0, 1'b0, 1'b1, 12'h5a5, 12'hfff};
    vecs[19] = '{12'd480, 12'd617, 1'b0, 1'b1, 1'b0, 12'h5a5, 12'hfff};
    blink_exp = '{12'h444, 12'h444, 12'h00f, 12'h00f, 12'h444, 12'h444, 12'h00f};

    // Reset with every input active: all outputs must read zero.
    rst = 1'b1;
    apply_stimulus(12'd433, 12'd401, 1'b0, 1'b1, 1'b0, 12'hfff);
    hsync_in = 1'b1; vsync_in = 1'b0; vblnk_in = 1'b0;
    xpos = 12'd450; ypos = 12'd420; mouse_left = 1'b0;
    tick(2);
    check_output("reset_rgb", rgb_out, 12'h000);
    check_output("reset_hcount", hcount_out, 12'h000);
    check_output("reset_sync", {8'h0, hsync_out, vsync_out, hblnk_out, vblnk_out}, 12'h000);
    check_output("reset_clicks", {9'h0, play_click, multi_click, menu_click}, 12'h000);
    hsync_in = 1'b0; xpos = 12'd0; ypos = 12'd0;
    rst = 1'b0;
    tick(1);

    for (int i = 0; i < 20; i++) begin
      apply_stimulus(vecs[i].h, vecs[i].v, vecs[i].hb, vecs[i].dms, vecs[i].dmb, vecs[i].rgb);
      tick(2);
      check_output($sformatf("vec%0d_rgb", i), rgb_out, vecs[i].exp);
      check_output($sformatf("vec%0d_hcount", i), hcount_out, vecs[i].h);
      check_output($sformatf("vec%0d_vcount", i), vcount_out, vecs[i].v);
    end

    // Hover is sampled only at a vsync rising edge.
    apply_stimulus(12'd500, 12'd440, 1'b0, 1'b1, 1'b0, 12'h5a5);
    vsync_pulse();
    tick(2);
    check_output("hover_pre", rgb_out, 12'h444);
    xpos = 12'd450; ypos = 12'd420;
    tick(3);
    check_output("hover_same_frame", rgb_out, 12'h444);
    vsync_pulse();
    tick(2);
    check_output("hover_latched", rgb_out, 12'h0f0);

    // Mid-line reset clears outputs next cycle and drops hover until the next frame.
    hsync_in = 1'b1;
    rst = 1'b1;
    tick(1);
    check_output("midreset_rgb", rgb_out, 12'h000);
    check_output("midreset_hsync", {11'h0, hsync_out}, 12'h000);
    check_output("midreset_hcount", hcount_out, 12'h000);
    rst = 1'b0;
    tick(2);
    check_output("postreset_hover_cleared", rgb_out, 12'h444);
    check_output("postreset_hsync", {11'h0, hsync_out}, 12'h001);
    hsync_in = 1'b0;
    vsync_pulse();
    tick(2);
    check_output("postreset_hover_relatched", rgb_out, 12'h0f0);

    // Clicks: long press yields exactly one pulse on the visible box under the mouse.
    xpos = 12'd450; ypos = 12'd560;
    apply_stimulus(12'd0, 12'd0, 1'b0, 1'b1, 1'b0, 12'h000);
    count_clicks(8, 5, np, nm, nn, multi);
    check_output("click_multi_count", 12'(nm), 12'd1);
    check_output("click_play_count", 12'(np), 12'd0);
    check_output("click_menu_count", 12'(nn), 12'd0);
    display_menu_button = 1'b1;
    tick(1);
    count_clicks(8, 5, np, nm, nn, multi);
    check_output("menuclick_menu_count", 12'(nn), 12'd1);
    check_output("menuclick_multi_count", 12'(nm), 12'd0);
    check_output("click_onehot", 12'(multi), 12'd0);
    xpos = 12'd0; ypos = 12'd0;
    count_clicks(6, 2, np, nm, nn, multi);
    check_output("click_outside", 12'(np + nm + nn), 12'd0);

    // Button held through reset release must not click; a fresh press does.
    display_menu_button = 1'b0;
    xpos = 12'd450; ypos = 12'd420;
    mouse_left = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    np = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      np += int'(play_click);
    end
    check_output("held_through_reset", 12'(np), 12'd0);
    mouse_left = 1'b0;
    tick(1);
    count_clicks(4, 2, np, nm, nn, multi);
    check_output("fresh_press_play", 12'(np), 12'd1);

    // Blink phase with BF=2 frames per half-period.
    xpos = 12'd0; ypos = 12'd0;
    apply_stimulus(12'd480, 12'd560, 1'b0, 1'b0, 1'b0, 12'h321);
    vsync_pulse();
    display_menu_button = 1'b1;
    for (int f = 0; f < 7; f++) begin
      tick(2);
      check_output($sformatf("blink_frame%0d", f), rgb_out, blink_exp[f]);
      if (f < 6) vsync_pulse();
    end
    display_menu_button = 1'b0;
    tick(1);
    display_menu_button = 1'b1;
    tick(2);
    check_output("blink_after_drop", rgb_out, 12'h444);
    vsync_pulse();
    tick(1);
    check_output("blink_after_drop_e1", rgb_out, 12'h444);
    vsync_pulse();
    tick(1);
    check_output("blink_after_drop_e2", rgb_out, 12'h00f);

    // Randomized run against the reference model.
    rst = 1'b1;
    apply_stimulus(12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 12'h000);
    hsync_in = 1'b0; vsync_in = 1'b0; vblnk_in = 1'b0; mouse_left = 1'b0;
    xpos = 12'd0; ypos = 12'd0;
    tick(2);
    rst = 1'b0;
    m_hov = '{0, 0, 0};
    m_frames = 0; m_vs_prev = 0; m_ml_prev = 0;
    pushed = 0;
    p1 = '{12'h0, 12'h0, 4'h0, 12'h0};
    p2 = p1;
    c1 = 3'b000;
    for (int c = 0; c < N_RAND; c++) begin
      tick(1);
      if (pushed >= 2) begin
        check_output("rand_rgb", rgb_out, p2.rgb);
        check_output("rand_hcount", hcount_out, p2.h);
        check_output("rand_vcount", vcount_out, p2.v);
        check_output("rand_sync", {8'h0, hsync_out, vsync_out, hblnk_out, vblnk_out}, {8'h0, p2.sync});
      end
      if (pushed >= 1)
        check_output("rand_clicks", {9'h0, play_click, multi_click, menu_click}, {9'h0, c1});

      hcount_in = $urandom_range(0, 1) ? 12'($urandom_range(400, 660)) : 12'($urandom_range(0, 1023));
      vcount_in = $urandom_range(0, 1) ? 12'($urandom_range(380, 640)) : 12'($urandom_range(0, 767));
      xpos      = $urandom_range(0, 3) != 0 ? 12'($urandom_range(420, 580)) : 12'($urandom_range(0, 1023));
      ypos      = $urandom_range(0, 3) != 0 ? 12'($urandom_range(390, 630)) : 12'($urandom_range(0, 767));
      rgb_in    = 12'($urandom_range(0, 4095));
      hsync_in  = $urandom_range(0, 7) == 0;
      vsync_in  = $urandom_range(0, 19) == 0;
      hblnk_in  = $urandom_range(0, 7) == 0;
      vblnk_in  = $urandom_range(0, 11) == 0;
      if ($urandom_range(0, 3) == 0) mouse_left = ~mouse_left;
      if ($urandom_range(0, 59) == 0) display_buttons_m_and_s = ~display_buttons_m_and_s;
      if ($urandom_range(0, 149) == 0) display_menu_button = ~display_menu_button;

      vs_rise = vsync_in && !m_vs_prev;
      if (!display_menu_button) m_frames = 0;
      else if (vs_rise) m_frames++;
      if (vs_rise)
        for (int i = 0; i < 3; i++) m_hov[i] = m_in_box(i, int'(xpos), int'(ypos));
      m_vs_prev = vsync_in;
      phase = ((m_frames / BF) % 2) == 1;
      pn.h = hcount_in;
      pn.v = vcount_in;
      pn.sync = {hsync_in, vsync_in, hblnk_in, vblnk_in};
      pn.rgb = m_colour(int'(hcount_in), int'(vcount_in), hblnk_in || vblnk_in,
                        display_buttons_m_and_s, display_menu_button, rgb_in, phase);
      press = mouse_left && !m_ml_prev;
      m_ml_prev = mouse_left;
      for (int i = 0; i < 3; i++)
        cn[2 - i] = press && m_visible(i, display_buttons_m_and_s, display_menu_button) &&
                    m_in_box(i, int'(xpos), int'(ypos));
      p2 = p1;
      p1 = pn;
      c1 = cn;
      pushed++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
